// File: rtl/match_run_logger.sv
// Converts the detector's z level into run-length records, buffered in a small
// FIFO drained over valid/ready, with run-start counting and sticky overflow.
module match_run_logger #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     z,
  input  logic                     out_ready,
  input  logic                     ovf_clr,
  output logic                     out_valid,
  output logic [LEN_W-1:0]         out_len,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         event_count,
  output logic                     overflow,
  output logic                     active
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [AW:0]      FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] run_cnt, run_cnt_nx;
  logic             push, start;

  logic [LEN_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, pop, wr_en, drop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational blocks use blocking assignments.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state   <= IDLE;
      run_cnt <= '0;
    end else begin
      state   <= state_nx;
      run_cnt <= run_cnt_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    run_cnt_nx = run_cnt;
    push       = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (z) begin
          state_nx   = RUN;
          run_cnt_nx = LEN_W'(1);
          start      = 1'b1;
        end
      end
      RUN: begin
        if (z) begin
          if (run_cnt != LEN_MAX) run_cnt_nx = run_cnt + LEN_W'(1);
        end else begin
          push       = 1'b1;
          state_nx   = IDLE;
          run_cnt_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == FULL_LEVEL);
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign out_len   = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign active    = (state == RUN);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      event_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      if (start) event_count <= event_count + CNT_W'(1);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // NOTE: storage is not reset; the pointers define which entries are live,
  // and an unreset array maps onto plain RAM/register-file cells.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= run_cnt;
  end

endmodule
